// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Contents: instruction/address widths, default queue size, opcodes used by
// static prediction, the queue entry payload and immediate-decode helpers.
package inst_fetcher_pkg;

    localparam int unsigned INST_WIDTH         = 32;
    localparam int unsigned XLEN               = 32;
    localparam int unsigned IQ_CAP_BIT_DEFAULT = 3;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    // One buffered instruction together with its fetch PC and prediction.
    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       pred_pc;
        logic                  taken;
    } iq_entry_t;

    // Sign-extended J-type immediate.
    function automatic logic [XLEN-1:0] j_imm(input logic [INST_WIDTH-1:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Sign-extended B-type immediate.
    function automatic logic [XLEN-1:0] b_imm(input logic [INST_WIDTH-1:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Bus bundle of the fetch stage: instruction port towards the memory unit and
// the queue-head handshake towards the decoder.
//   master : fetch stage (drives mem_pc/mem_inst_req and out_*)
//   slave  : environment (memory unit + decoder)
interface inst_fetcher_if;
    import inst_fetcher_pkg::*;

    logic [XLEN-1:0]       mem_pc;
    logic                  mem_inst_req;
    logic                  mem_inst_ready;
    logic [INST_WIDTH-1:0] mem_inst_res;

    logic                  out_valid;
    logic [INST_WIDTH-1:0] out_inst;
    logic [XLEN-1:0]       out_pc;
    logic [XLEN-1:0]       out_pred_pc;
    logic                  out_pred_taken;
    logic                  dec_ready;

    modport master (
        output mem_pc, mem_inst_req,
        input  mem_inst_ready, mem_inst_res,
        output out_valid, out_inst, out_pc, out_pred_pc, out_pred_taken,
        input  dec_ready
    );

    modport slave (
        input  mem_pc, mem_inst_req,
        output mem_inst_ready, mem_inst_res,
        input  out_valid, out_inst, out_pc, out_pred_pc, out_pred_taken,
        output dec_ready
    );

endinterface

// File: rtl/inst_fetcher_inst_queue.sv
// In-order circular instruction queue of depth 1<<CAP_BIT.
// Ports: clk, rst (async active-high); push/push_entry write at tail; pop
// advances head; flush empties the queue; head_entry is the oldest entry;
// count is the occupancy (0..depth); full flags count==depth.
// Callers must not push when full nor pop when empty.
module inst_fetcher_inst_queue
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned CAP_BIT = IQ_CAP_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  iq_entry_t        push_entry,
    output iq_entry_t        head_entry,
    output logic [CAP_BIT:0] count,
    output logic             full
);

    localparam int unsigned DEPTH = 1 << CAP_BIT;

    iq_entry_t          mem [DEPTH];
    logic [CAP_BIT-1:0] head;
    logic [CAP_BIT-1:0] tail;

    // Pointers wrap naturally at CAP_BIT bits; flush leaves storage untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_entry;
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head_entry = mem[head];
    assign full       = (count == (CAP_BIT+1)'(DEPTH));

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: owns the fetch PC, requests instructions from the
// memory unit, computes the next PC and buffers fetched instructions for the
// decoder. A clear from the ROB flushes the queue and redirects the PC.
// Ports: clk_in, rst_in (async active-high), rdy_in (freezes all state when
// low), clear/clear_pc (ROB redirect), bus (inst_fetcher_if.master: memory
// instruction port and decoder queue-head handshake).
// Optional: define IFETCH_STATIC_PREDICT_EN to predict JAL and backward
// branches as taken; otherwise every instruction predicts pc+4, not taken.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned     IQ_CAP_BIT = IQ_CAP_BIT_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            clear,
    input  logic [XLEN-1:0] clear_pc,
    inst_fetcher_if.master  bus
);

    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     next_pc;
    logic                taken;
    logic [IQ_CAP_BIT:0] count;
    logic                full;
    logic                req;
    logic                accept;
    logic                pop;
    logic                flush;
    iq_entry_t           push_entry;
    iq_entry_t           head_entry;

    // Occupancy alone gates the request: a same-cycle pop does not free a slot.
    assign req    = !rst_in && !clear && !full;
    assign accept = req && bus.mem_inst_ready && rdy_in;
    assign pop    = (count != '0) && bus.dec_ready && rdy_in && !clear;
    assign flush  = clear && rdy_in;

    // Next-PC and taken prediction for the word currently returned by memory.
    always_comb begin
        next_pc = pc + 32'd4;
        taken   = 1'b0;
`ifdef IFETCH_STATIC_PREDICT_EN
        if (bus.mem_inst_res[6:0] == OPCODE_JAL) begin
            next_pc = pc + j_imm(bus.mem_inst_res);
            taken   = 1'b1;
        end else if (bus.mem_inst_res[6:0] == OPCODE_BRANCH && bus.mem_inst_res[31]) begin
            // Backward branches (negative offset) are assumed to be loops.
            next_pc = pc + b_imm(bus.mem_inst_res);
            taken   = 1'b1;
        end
`endif
    end

    // Fetch PC: redirect has priority, otherwise advance on an accepted fetch.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc <= RESET_PC;
        end else if (rdy_in) begin
            if (clear) begin
                pc <= clear_pc;
            end else if (accept) begin
                pc <= next_pc;
            end
        end
    end

    assign push_entry = '{inst: bus.mem_inst_res, pc: pc, pred_pc: next_pc, taken: taken};

    inst_fetcher_inst_queue #(
        .CAP_BIT (IQ_CAP_BIT)
    ) u_queue (
        .clk        (clk_in),
        .rst        (rst_in),
        .push       (accept),
        .pop        (pop),
        .flush      (flush),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .count      (count),
        .full       (full)
    );

    assign bus.mem_pc         = pc;
    assign bus.mem_inst_req   = req;
    assign bus.out_valid      = (count != '0);
    assign bus.out_inst       = head_entry.inst;
    assign bus.out_pc         = head_entry.pc;
    assign bus.out_pred_pc    = head_entry.pred_pc;
    assign bus.out_pred_taken = head_entry.taken;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed scenarios plus a randomized
// run against a queue-based reference model of the fetch stage.
module tb_inst_fetcher;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
        logic        tk;
    } ent_t;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        rdy    = 1'b0;
    logic        clr    = 1'b0;
    logic [31:0] clr_pc = '0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] m_pc;
    ent_t        mq[$];
    logic [31:0] imem [int unsigned];

    inst_fetcher_if bus();

    inst_fetcher dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .rdy_in   (rdy),
        .clear    (clr),
        .clear_pc (clr_pc),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: table entries, else a harmless addi-like word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (imem.exists(a)) return imem[a];
        return {a[26:2] ^ 25'h0ABCDEF, 7'h13};
    endfunction

    // Reference prediction computed from the immediate's arithmetic meaning.
    function automatic void ref_predict(input logic [31:0] p, input logic [31:0] w,
                                        output logic [31:0] npc, output logic tk);
        int off;
        off = 4;
        tk  = 1'b0;
`ifdef IFETCH_STATIC_PREDICT_EN
        if (w[6:0] == 7'h6F) begin
            off = (w[31] ? -(1 << 20) : 0) + (int'(w[19:12]) << 12) + (int'(w[20]) << 11)
                + (int'(w[30:21]) << 1);
            tk  = 1'b1;
        end else if (w[6:0] == 7'h63 && w[31]) begin
            off = -4096 + (int'(w[7]) << 11) + (int'(w[30:25]) << 5) + (int'(w[11:8]) << 1);
            tk  = 1'b1;
        end
`endif
        npc = p + 32'(off);
    endfunction

    task automatic drive(input logic r, input logic c, input logic [31:0] cp,
                         input logic h, input logic d);
        @(negedge clk);
        rdy                = r;
        clr                = c;
        clr_pc             = cp;
        bus.mem_inst_ready = h;
        bus.dec_ready      = d;
        bus.mem_inst_res   = mem_word(bus.mem_pc);
        #1;
    endtask

    // Apply the fetch-stage rules to the model for the current inputs, then clock.
    task automatic advance();
        ent_t        e;
        logic [31:0] npc;
        logic        tk;
        int          sz;
        sz = mq.size();
        if (rdy) begin
            if (clr) begin
                m_pc = clr_pc;
                mq.delete();
            end else begin
                if (sz != 0 && bus.dec_ready) void'(mq.pop_front());
                if (sz < 8 && bus.mem_inst_ready) begin
                    ref_predict(m_pc, mem_word(m_pc), npc, tk);
                    e.inst = mem_word(m_pc);
                    e.pc   = m_pc;
                    e.pred = npc;
                    e.tk   = tk;
                    mq.push_back(e);
                    m_pc = npc;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rdy = 1'b0; clr = 1'b0; bus.mem_inst_ready = 1'b0; bus.dec_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_pc = 32'h0;
        mq.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            advance();
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        m_pc = 32'h0;
        mq.delete();
        checks++; if (bus.mem_pc !== 32'h0) begin errors++; $display("FAIL reset_mem_pc got %h exp %h", bus.mem_pc, 32'h0); end
        checks++; if (bus.mem_inst_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.mem_inst_req); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", bus.out_inst); end
        checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h exp 0", bus.out_pc); end
        checks++; if (bus.out_pred_pc !== 32'h0) begin errors++; $display("FAIL reset_pred_pc got %h exp 0", bus.out_pred_pc); end
        checks++; if (bus.out_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", bus.out_pred_taken); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.mem_inst_req !== 1'b1) begin errors++; $display("FAIL post_reset_req got %b exp 1", bus.mem_inst_req); end
    endtask

    task automatic test_stream();
        logic [31:0] words [3];
        words = '{32'h00100093, 32'h00200113, 32'h00300193};
        for (int i = 0; i < 3; i++) imem[32'(4 * i)] = words[i];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h0, i < 3, 1'b1);
            if (i < 4) begin
                checks++; if (bus.mem_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_mem_pc[%0d] got %h exp %h", i, bus.mem_pc, 32'(4 * i)); end
            end
            checks++; if (bus.out_valid !== (i >= 1 && i <= 3)) begin errors++; $display("FAIL stream_valid[%0d] got %b", i, bus.out_valid); end
            if (i >= 1 && i <= 3) begin
                checks++; if (bus.out_pc !== 32'(4 * (i - 1))) begin errors++; $display("FAIL stream_out_pc[%0d] got %h exp %h", i, bus.out_pc, 32'(4 * (i - 1))); end
                checks++; if (bus.out_pred_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pred_pc[%0d] got %h exp %h", i, bus.out_pred_pc, 32'(4 * i)); end
                checks++; if (bus.out_inst !== words[i - 1]) begin errors++; $display("FAIL stream_inst[%0d] got %h exp %h", i, bus.out_inst, words[i - 1]); end
            end
            advance();
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            checks++; if (bus.mem_inst_req !== 1'b1) begin errors++; $display("FAIL fill_req[%0d] got %b exp 1", i, bus.mem_inst_req); end
            advance();
        end
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.mem_inst_req !== 1'b0) begin errors++; $display("FAIL full_req got %b exp 0", bus.mem_inst_req); end
        checks++; if (bus.mem_pc !== 32'h20) begin errors++; $display("FAIL full_mem_pc got %h exp 20", bus.mem_pc); end
        checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL full_out_pc got %h exp 0", bus.out_pc); end
        advance();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        checks++; if (bus.mem_inst_req !== 1'b0) begin errors++; $display("FAIL full_pop_req got %b exp 0", bus.mem_inst_req); end
        advance();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.mem_inst_req !== 1'b1) begin errors++; $display("FAIL after_pop_req got %b exp 1", bus.mem_inst_req); end
        checks++; if (bus.mem_pc !== 32'h20) begin errors++; $display("FAIL after_pop_mem_pc got %h exp 20", bus.mem_pc); end
        checks++; if (bus.out_pc !== 32'h4) begin errors++; $display("FAIL after_pop_out_pc got %h exp 4", bus.out_pc); end
        advance();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.mem_pc !== 32'h24) begin errors++; $display("FAIL refill_mem_pc got %h exp 24", bus.mem_pc); end
        checks++; if (bus.mem_inst_req !== 1'b0) begin errors++; $display("FAIL refill_req got %b exp 0", bus.mem_inst_req); end
        advance();
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            advance();
        end
        drive(1'b1, 1'b1, 32'h1000, 1'b1, 1'b1);
        checks++; if (bus.mem_inst_req !== 1'b0) begin errors++; $display("FAIL clear_req got %b exp 0", bus.mem_inst_req); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL clear_pre_valid got %b exp 1", bus.out_valid); end
        advance();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.mem_pc !== 32'h1000) begin errors++; $display("FAIL clear_mem_pc got %h exp 1000", bus.mem_pc); end
        checks++; if (bus.mem_inst_req !== 1'b1) begin errors++; $display("FAIL clear_next_req got %b exp 1", bus.mem_inst_req); end
        advance();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        advance();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (bus.out_pc !== 32'h1000) begin errors++; $display("FAIL redirect_out_pc got %h exp 1000", bus.out_pc); end
        checks++; if (bus.mem_pc !== 32'h1004) begin errors++; $display("FAIL redirect_mem_pc got %h exp 1004", bus.mem_pc); end
        advance();
    endtask

    task automatic test_freeze();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, k == 1, 32'h500, 1'b1, 1'b1);
            checks++; if (bus.mem_pc !== 32'hC) begin errors++; $display("FAIL freeze_mem_pc[%0d] got %h exp c", k, bus.mem_pc); end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8) begin errors++; $display("FAIL freeze_head[%0d] got %b/%h exp 1/8", k, bus.out_valid, bus.out_pc); end
            checks++; if (bus.out_inst !== mem_word(32'h8)) begin errors++; $display("FAIL freeze_inst[%0d] got %h exp %h", k, bus.out_inst, mem_word(32'h8)); end
            advance();
        end
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        checks++; if (bus.mem_pc !== 32'hC || bus.out_pc !== 32'h8) begin errors++; $display("FAIL resume got %h/%h exp c/8", bus.mem_pc, bus.out_pc); end
        advance();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (bus.mem_pc !== 32'h10 || bus.out_pc !== 32'hC) begin errors++; $display("FAIL resume_next got %h/%h exp 10/c", bus.mem_pc, bus.out_pc); end
        advance();
    endtask

    task automatic test_predict();
        logic [31:0] ta [5];
        logic [31:0] tn [5];
        logic        tt [5];
        imem[32'h40]  = 32'hFE000EE3;
        imem[32'h100] = 32'h0080006F;
        imem[32'h200] = 32'h00000463;
        imem[32'h300] = 32'h00008067;
        ta = '{32'h40, 32'h100, 32'h200, 32'h300, 32'hFFFFFFFC};
`ifdef IFETCH_STATIC_PREDICT_EN
        tn = '{32'h3C, 32'h108, 32'h204, 32'h304, 32'h0};
        tt = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
        tn = '{32'h44, 32'h104, 32'h204, 32'h304, 32'h0};
        tt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, ta[i], 1'b0, 1'b1);
            advance();
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            checks++; if (bus.mem_pc !== ta[i]) begin errors++; $display("FAIL pred_fetch[%0d] got %h exp %h", i, bus.mem_pc, ta[i]); end
            advance();
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            checks++; if (bus.mem_pc !== tn[i]) begin errors++; $display("FAIL pred_next_pc[%0d] got %h exp %h", i, bus.mem_pc, tn[i]); end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== ta[i]) begin errors++; $display("FAIL pred_head[%0d] got %b/%h exp 1/%h", i, bus.out_valid, bus.out_pc, ta[i]); end
            checks++; if (bus.out_pred_pc !== tn[i]) begin errors++; $display("FAIL pred_out_pred_pc[%0d] got %h exp %h", i, bus.out_pred_pc, tn[i]); end
            checks++; if (bus.out_pred_taken !== tt[i]) begin errors++; $display("FAIL pred_taken[%0d] got %b exp %b", i, bus.out_pred_taken, tt[i]); end
            advance();
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic        c;
        for (int a = 0; a < 256; a++) begin
            w = $urandom;
            case ($urandom_range(0, 5))
                0:       w[6:0] = 7'h6F;
                1:       w[6:0] = 7'h63;
                2:       w[6:0] = 7'h67;
                default: w[6:0] = 7'h13;
            endcase
            imem[32'(4 * a)] = w;
        end
        do_reset();
        for (int n = 0; n < 800; n++) begin
            c = ($urandom_range(0, 15) == 0);
            drive($urandom_range(0, 9) != 0, c, 32'($urandom_range(0, 255)) << 2,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
            checks++; if (bus.mem_pc !== m_pc) begin errors++; $display("FAIL rnd_mem_pc[%0d] got %h exp %h", n, bus.mem_pc, m_pc); end
            checks++; if (bus.mem_inst_req !== (!c && mq.size() < 8)) begin errors++; $display("FAIL rnd_req[%0d] got %b exp %b", n, bus.mem_inst_req, (!c && mq.size() < 8)); end
            checks++; if (bus.out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, bus.out_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                checks++;
                if (bus.out_inst !== mq[0].inst || bus.out_pc !== mq[0].pc ||
                    bus.out_pred_pc !== mq[0].pred || bus.out_pred_taken !== mq[0].tk) begin
                    errors++;
                    $display("FAIL rnd_head[%0d] got %h/%h/%h/%b exp %h/%h/%h/%b", n,
                             bus.out_inst, bus.out_pc, bus.out_pred_pc, bus.out_pred_taken,
                             mq[0].inst, mq[0].pc, mq[0].pred, mq[0].tk);
                end
            end
            advance();
        end
    endtask

    initial begin
        bus.mem_inst_ready = 1'b0;
        bus.mem_inst_res   = '0;
        bus.dec_ready      = 1'b0;
        m_pc               = 32'h0;
        test_reset();
        test_stream();
        test_full();
        test_clear();
        test_freeze();
        test_predict();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
